dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter DEPTH, default 400, giving the data-memory depth in words.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have, for each requester x in {0,1} (m0 = CPU load/store, m1 = loader/debug master), these inputs:
- mx_req, 1: request.
- mx_we, 1: write enable.
- mx_addr, 32: address.
- mx_wdata, 32: write data.
- mx_byte_en, 2: access size.
- mx_funct3, 3: load type.
REQ-005 The module SHALL have, for each x, these outputs:
- mx_gnt, 1: request accepted.
- mx_done, 1: access complete.
- mx_rdata, 32: load data.
- mx_err, 1: address out of range.
REQ-006 The module SHALL have memory-side outputs d_wr_en (1), dAddr (32), dWdata (32), byte_en (2) and funct3_in (3), plus input dRdata (32), the combinational read data.

Function
REQ-007 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-008 In IDLE, or in RESP, with any mx_req high, the module SHALL combinationally assert exactly one mx_gnt, capture that requester's fields into internal registers at the clock edge, and move to ACCESS.
REQ-009 A requester SHALL hold req and fields stable until it sees gnt; gnt SHALL be high for exactly one cycle per accepted request.
REQ-010 With no req in IDLE, the FSM SHALL stay in IDLE; with no req in RESP, it SHALL go to IDLE.
REQ-011 In ACCESS, the module SHALL drive the memory port from the captured registers for exactly one cycle, then go to RESP.
REQ-012 In ACCESS, d_wr_en SHALL equal the captured we, except when captured addr >= DEPTH, in which case d_wr_en = 0.
REQ-013 In ACCESS with a read, the module SHALL latch dRdata into the owner's rdata register, or latch 0 when addr >= DEPTH.
REQ-014 In RESP, the module SHALL pulse done to the owner for one cycle, and assert err in the same cycle if addr >= DEPTH.
REQ-015 mx_rdata SHALL hold its value until the next read completes for that requester.
REQ-016 Outside ACCESS, all memory-side outputs SHALL be 0.
REQ-017 Latency from gnt cycle to done SHALL be 2 cycles, and back-to-back throughput SHALL be one access per 2 cycles (RESP grants the next request).
REQ-018 When both req are high, the arbitration rule per REQ-023 SHALL apply.
REQ-019 Both done signals SHALL never be high in the same cycle.

Reset
REQ-020 On reset_n low, the module SHALL immediately force state IDLE and set all gnt/done/err/rdata and memory-side outputs to 0, so d_wr_en drops asynchronously and no write occurs.
REQ-021 On reset_n low, the last-grant register SHALL be set to 1 so that m0 wins the first contention.
REQ-022 A reset during ACCESS or RESP SHALL discard the in-flight access with no done pulse; requesters must re-request.

Configuration
REQ-023 With macro DMEM_ARB_RR_EN defined, contention SHALL be resolved round-robin: grant the requester not granted last, and update last-grant on every gnt.
REQ-024 Without DMEM_ARB_RR_EN, m0 SHALL always have fixed priority over m1, and last-grant SHALL be unused.

Verification
REQ-025 Single m0 write: m0_req=1, we=1, addr=5, wdata=0x12345678, byte_en=2'b11 -> m0_gnt in cycle 0, d_wr_en=1 with dAddr=5 in cycle 1, m0_done in cycle 2, mem[5]=0x12345678.
REQ-026 m0 read after write: funct3=3'b000, mem[5]=0x000000F0 -> m0_rdata=0xFFFFFFF0 with m0_done, 2 cycles after gnt.
REQ-027 Both req held high for 4 grants, RR_EN defined -> grant order m0,m1,m0,m1, gnt spacing 2 cycles; without macro -> m0 wins every grant while it keeps requesting.
REQ-028 m1 write to addr=400 -> d_wr_en stays 0, m1_done and m1_err high in the same cycle, m1_rdata unchanged.
REQ-029 reset_n asserted during ACCESS of an m0 write -> d_wr_en=0 immediately, memory unchanged, no m0_done; after release, IDLE and m0 wins the first contention.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: IDLE -> ACCESS -> RESP handshake with one access per two cycles.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise m0 has fixed priority.
module dmem_arbiter #(
    parameter int DEPTH = 400
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_byte_en,
    input  logic [2:0]  m0_funct3,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_byte_en,
    input  logic [2:0]  m1_funct3,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        d_wr_en,
    output logic [31:0] dAddr,
    output logic [31:0] dWdata,
    output logic [1:0]  byte_en,
    output logic [2:0]  funct3_in,
    input  logic [31:0] dRdata
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;

    logic        owner_q;
    logic        we_q;
    logic        oor_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  byte_en_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q [2];

    logic        sel;
    logic        grant_ok;
    logic        in_access;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_byte_en;
    logic [2:0]  sel_funct3;

`ifdef DMEM_ARB_RR_EN
    logic        last_q;
`endif

    // Winner selection; only meaningful when grant_ok is high.
    always_comb begin
        sel = m1_req;
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            sel = ~last_q;
`else
            sel = 1'b0;
`endif
        end
    end

    // Gated by reset_n so no grant (and no capture) is seen while held in reset.
    assign grant_ok = reset_n && (state_q != ACCESS) && (m0_req || m1_req);
    assign in_access = (state_q == ACCESS);

    assign sel_we      = sel ? m1_we      : m0_we;
    assign sel_addr    = sel ? m1_addr    : m0_addr;
    assign sel_wdata   = sel ? m1_wdata   : m0_wdata;
    assign sel_byte_en = sel ? m1_byte_en : m0_byte_en;
    assign sel_funct3  = sel ? m1_funct3  : m0_funct3;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_ok ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = grant_ok ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m0_gnt    = grant_ok && !sel;
        m1_gnt    = grant_ok && sel;
        m0_done   = (state_q == RESP) && !owner_q;
        m1_done   = (state_q == RESP) && owner_q;
        m0_err    = m0_done && oor_q;
        m1_err    = m1_done && oor_q;
        m0_rdata  = rdata_q[0];
        m1_rdata  = rdata_q[1];
        d_wr_en   = in_access && we_q && !oor_q;
        dAddr     = in_access ? addr_q    : 32'd0;
        dWdata    = in_access ? wdata_q   : 32'd0;
        byte_en   = in_access ? byte_en_q : 2'd0;
        funct3_in = in_access ? funct3_q  : 3'd0;
    end

    // Request capture and per-requester load-data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_en_q  <= '0;
            funct3_q   <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            if (grant_ok) begin
                owner_q   <= sel;
                we_q      <= sel_we;
                oor_q     <= (sel_addr >= DEPTH_W);
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
                byte_en_q <= sel_byte_en;
                funct3_q  <= sel_funct3;
            end
            if (in_access && !we_q) begin
                rdata_q[owner_q] <= oor_q ? 32'd0 : dRdata;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to m1 so that m0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (grant_ok) begin
            last_q <= sel;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: word-indexed memory model with load extension and a completion scoreboard.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_byte_en, m1_byte_en;
    logic [2:0]  m0_funct3, m1_funct3;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        d_wr_en;
    logic [31:0] dAddr, dWdata, dRdata;
    logic [1:0]  byte_en;
    logic [2:0]  funct3_in;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata [2];
    logic [31:0] mem [0:511];

    dmem_arbiter #(.DEPTH(400)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byte_en(m0_byte_en), .m0_funct3(m0_funct3),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byte_en(m1_byte_en), .m1_funct3(m1_funct3),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .d_wr_en(d_wr_en), .dAddr(dAddr), .dWdata(dWdata), .byte_en(byte_en),
        .funct3_in(funct3_in), .dRdata(dRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: byte_en 00=byte, 01=half, else word; loads extended per funct3.
    always @(posedge clk) begin
        if (d_wr_en && dAddr < 32'd400) begin
            case (byte_en)
                2'b00:   mem[dAddr[8:0]][7:0]  <= dWdata[7:0];
                2'b01:   mem[dAddr[8:0]][15:0] <= dWdata[15:0];
                default: mem[dAddr[8:0]]       <= dWdata;
            endcase
        end
    end

    always_comb begin
        logic [31:0] w;
        w = (dAddr < 32'd400) ? mem[dAddr[8:0]] : 32'd0;
        case (funct3_in)
            3'b000:  dRdata = {{24{w[7]}}, w[7:0]};
            3'b001:  dRdata = {{16{w[15]}}, w[15:0]};
            3'b100:  dRdata = {24'd0, w[7:0]};
            3'b101:  dRdata = {16'd0, w[15:0]};
            default: dRdata = w;
        endcase
    end

    // Completion monitor: every done pops the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m0_done && m1_done) begin
                total++; bad++;
                $display("FAIL both_done: m0_done=1 m1_done=1 required at most one");
            end
            for (int m = 0; m < 2; m++) begin
                logic        d;
                logic        e;
                logic [31:0] r;
                d = m ? m1_done : m0_done;
                e = m ? m1_err : m0_err;
                r = m ? m1_rdata : m0_rdata;
                if (d) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: m%0d done with no pending request", m);
                    end else begin
                        exp_t x;
                        x = sb.pop_front();
                        if (x.m != m || r !== x.rdata || e !== x.err || cyc != x.cyc + 2) begin
                            bad++;
                            $display("FAIL sb_done: got m%0d rdata=%h err=%0b cyc=%0d, required m%0d rdata=%h err=%0b cyc=%0d",
                                     m, r, e, cyc, x.m, x.rdata, x.err, x.cyc + 2);
                        end else begin
                            $display("txn m%0d done rdata=%h err=%0b cyc=%0d", m, r, e, cyc);
                        end
                    end
                end
            end
        end
    end

    function automatic logic gnt_of(input int m);
        return m ? m1_gnt : m0_gnt;
    endfunction

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] be, input logic [2:0] f3);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_byte_en = be; m0_funct3 = f3;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_byte_en = be; m1_funct3 = f3;
        end
    endtask

    // Issue one request and wait for its grant; returns #1 after the grant edge (ACCESS cycle).
    task automatic issue(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] be, input logic [2:0] f3, input logic [31:0] exp_rd);
        int n;
        exp_t x;
        @(negedge clk);
        drive(m, 1'b1, we, addr, wdata, be, f3);
        #1;
        n = 0;
        while (!gnt_of(m) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (!gnt_of(m)) begin
            bad++;
            $display("FAIL gnt_timeout: m%0d gnt=0 required 1 within 20 cycles", m);
            drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
            return;
        end
        if (!we) model_rdata[m] = exp_rd;
        x.m = m; x.rdata = model_rdata[m]; x.err = (addr >= 32'd400); x.cyc = cyc;
        sb.push_back(x);
        $display("txn m%0d gnt we=%0b addr=%0d wdata=%h cyc=%0d", m, we, addr, wdata, cyc);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
        model_rdata[0] = '0; model_rdata[1] = '0;
        #2;
        total++;
        if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, d_wr_en} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, d_wr_en});
        end
        total++;
        if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0 || dAddr !== 32'd0 || dWdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: m0_rdata=%h m1_rdata=%h dAddr=%h dWdata=%h required 0",
                     m0_rdata, m1_rdata, dAddr, dWdata);
        end
        m0_req = 1'b1;
        #1;
        total++;
        if (m0_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_gnt: m0_gnt=%b required 0 during reset", m0_gnt);
        end
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("txn reset released cyc=%0d", cyc);
    endtask

    task automatic test_reset_during_access;
        issue(1, 1'b1, 32'd20, 32'h1111_1111, 2'b11, 3'b010, 32'd0);
        issue(0, 1'b1, 32'd20, 32'hDEAD_BEEF, 2'b11, 3'b010, 32'd0);
        void'(sb.pop_back());
        total++;
        if (d_wr_en !== 1'b1 || dAddr !== 32'd20) begin
            bad++;
            $display("FAIL abort_access: d_wr_en=%b dAddr=%0d required 1/20", d_wr_en, dAddr);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (d_wr_en !== 1'b0 || dAddr !== 32'd0) begin
            bad++;
            $display("FAIL abort_wr_en: d_wr_en=%b dAddr=%0d required 0/0", d_wr_en, dAddr);
        end
        model_rdata[0] = '0; model_rdata[1] = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("txn reset during access released cyc=%0d", cyc);
        repeat (3) @(negedge clk);
        total++;
        if (mem[20] !== 32'h1111_1111) begin
            bad++;
            $display("FAIL abort_mem: mem[20]=%h required 11111111", mem[20]);
        end
    endtask

    task automatic test_contention;
        int order[$];
        int gcyc[$];
        int exp_order[4];
        int n;
        exp_t x;
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'd10, 32'h0000_00A0, 2'b11, 3'b010);
        drive(1, 1'b1, 1'b1, 32'd11, 32'h0000_00B1, 2'b11, 3'b010);
        n = 0;
        while (order.size() < 4 && n < 40) begin
            #1;
            if (m0_gnt && m1_gnt) begin
                total++; bad++;
                $display("FAIL dual_gnt: m0_gnt=1 m1_gnt=1 required one");
            end
            if (m0_gnt || m1_gnt) begin
                x.m = m1_gnt ? 1 : 0; x.rdata = model_rdata[x.m]; x.err = 1'b0; x.cyc = cyc;
                sb.push_back(x);
                order.push_back(x.m);
                gcyc.push_back(cyc);
                $display("txn contention gnt m%0d cyc=%0d", x.m, cyc);
            end
            @(negedge clk);
            n++;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
        total++;
        if (order.size() != 4) begin
            bad++;
            $display("FAIL contention_count: grants=%0d required 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (order[i] != exp_order[i]) begin
                    bad++;
                    $display("FAIL contention_order[%0d]: m%0d required m%0d", i, order[i], exp_order[i]);
                end
                if (i > 0) begin
                    total++;
                    if (gcyc[i] - gcyc[i-1] != 2) begin
                        bad++;
                        $display("FAIL contention_spacing[%0d]: %0d cycles required 2", i, gcyc[i] - gcyc[i-1]);
                    end
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_write;
        issue(0, 1'b1, 32'd5, 32'h1234_5678, 2'b11, 3'b010, 32'd0);
        total++;
        if (d_wr_en !== 1'b1 || dAddr !== 32'd5 || dWdata !== 32'h1234_5678 || byte_en !== 2'b11) begin
            bad++;
            $display("FAIL write_port: d_wr_en=%b dAddr=%0d dWdata=%h byte_en=%b required 1/5/12345678/11",
                     d_wr_en, dAddr, dWdata, byte_en);
        end
        @(posedge clk); #1;
        total++;
        if (d_wr_en !== 1'b0 || dAddr !== 32'd0) begin
            bad++;
            $display("FAIL write_idle_port: d_wr_en=%b dAddr=%0d required 0/0 in RESP", d_wr_en, dAddr);
        end
        @(negedge clk);
        total++;
        if (mem[5] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL write_mem: mem[5]=%h required 12345678", mem[5]);
        end
    endtask

    task automatic test_read_sign;
        issue(0, 1'b1, 32'd5, 32'h0000_00F0, 2'b11, 3'b010, 32'd0);
        issue(0, 1'b0, 32'd5, 32'd0, 2'b11, 3'b000, 32'hFFFF_FFF0);
        issue(0, 1'b0, 32'd5, 32'd0, 2'b11, 3'b100, 32'h0000_00F0);
        issue(0, 1'b1, 32'd6, 32'h0000_8001, 2'b01, 3'b001, 32'd0);
        issue(0, 1'b0, 32'd6, 32'd0, 2'b01, 3'b001, 32'hFFFF_8001);
        issue(0, 1'b0, 32'd6, 32'd0, 2'b01, 3'b101, 32'h0000_8001);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_out_of_range;
        issue(1, 1'b0, 32'd5, 32'd0, 2'b11, 3'b010, 32'h0000_00F0);
        issue(1, 1'b1, 32'd400, 32'hBAD0_BAD0, 2'b11, 3'b010, 32'd0);
        total++;
        if (d_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL oor_wr_en: d_wr_en=%b required 0 for addr 400", d_wr_en);
        end
        issue(1, 1'b0, 32'd400, 32'd0, 2'b11, 3'b010, 32'd0);
        issue(1, 1'b1, 32'd399, 32'hCAFE_F00D, 2'b11, 3'b010, 32'd0);
        issue(1, 1'b0, 32'd399, 32'd0, 2'b11, 3'b010, 32'hCAFE_F00D);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'd100 + 32'(i);
            issue(i % 2, 1'b1, a, 32'h5A00_0000 + 32'(i), 2'b11, 3'b010, 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'd100 + 32'(i);
            issue((i + 1) % 2, 1'b0, a, 32'd0, 2'b11, 3'b010, 32'h5A00_0000 + 32'(i));
        end
    endtask

    initial begin
        int n;
        test_reset();
        test_reset_during_access();
        test_contention();
        test_single_write();
        test_read_sign();
        test_out_of_range();
        test_back_to_back();
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk); n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
